hit_judge: RTL and testbench
============================

HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter WINDOW_TICKS, default 16: length of each lane's hit window, counted in tick_en strobes, legal range 1..255.
REQ-002 Port clk, input, 1: system clock; all logic is on the rising edge.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Port tick_en, input, 1: single-cycle timing strobe (320 Hz rate) that advances the window counters.
REQ-005 Port play_en, input, 1: game-running qualifier; when low, judging is frozen.
REQ-006 Port note_arrive, input, 4: per-lane single-cycle pulse (d,f,j,k order [3:0]) marking a note entering the hit zone.
REQ-007 Port key_pulse, input, 4: per-lane single-cycle key press pulse, already debounced and one-pulsed.
REQ-008 Port score3..score0, output, 4 each: BCD score digits, thousands..units, direct feed to the seven-segment display.
REQ-009 Port combo, output, 8: current consecutive-hit count.
REQ-010 Port hit_flash, output, 4: per-lane single-cycle pulse, one per judged hit.
REQ-011 Port miss_flash, output, 4: per-lane single-cycle pulse, one per judged miss.

Function
REQ-012 Each lane SHALL run its own FSM with states IDLE and WINDOW, plus an 8-bit down-counter.
REQ-013 IDLE->WINDOW on note_arrive: load the counter with WINDOW_TICKS.
REQ-014 In WINDOW, each tick_en decrements the counter; when the counter is 1 and tick_en is high, the lane judges a miss and returns to IDLE.
REQ-015 In WINDOW, key_pulse judges a hit and returns the lane to IDLE.
REQ-016 key_pulse in IDLE SHALL be ignored: no score change, no flash, combo unchanged.
REQ-017 key_pulse and window expiry in the same cycle SHALL judge a hit.
REQ-018 note_arrive while in WINDOW with no key_pulse SHALL judge the pending note a miss and reload the counter (remain in WINDOW).
REQ-019 note_arrive and key_pulse in the same WINDOW cycle SHALL judge a hit on the pending note and reload the counter (remain in WINDOW).
REQ-020 hit_flash/miss_flash SHALL assert exactly one cycle, in the cycle after the judging edge.
REQ-021 Score SHALL add 1 per hit lane per cycle; up to 4 simultaneous hits are summed in one cycle.
REQ-022 Score SHALL be 4-digit BCD with decimal carries, updated one cycle after judgement, and SHALL saturate at 9999.
REQ-023 Combo SHALL increment by the number of hits in a cycle and saturate at 255.
REQ-024 Any miss in a cycle SHALL clear combo to 0, overriding hits in that same cycle; those hits still score.
REQ-025 play_en low SHALL hold all lane states, counters, score and combo; note_arrive, key_pulse and tick_en are ignored; flashes stay 0.

Reset
REQ-026 rst SHALL force all lanes to IDLE, all counters to 0, score digits to 0, combo to 0, and all flashes to 0 on the next edge.
REQ-027 rst SHALL take priority over every other input, including mid-window; no flash is emitted for discarded notes.

Configuration
REQ-028 With macro HIT_JUDGE_COMBO_BONUS_EN defined, a hit whose pre-update combo is >= 10 SHALL score 2; otherwise 1 (per-cycle maximum 8).
REQ-029 With HIT_JUDGE_COMBO_BONUS_EN undefined, every hit SHALL score 1, and no bonus logic is synthesised.

Structure
REQ-030 Shared package rg_pkg SHALL hold the lane-state enum (IDLE, WINDOW), the BCD digit type, NUM_LANES=4 and the score ceiling 9999.
REQ-031 The per-lane FSM and counter SHALL be a sub-module lane_judge, instantiated four times; score/combo accumulation stays in hit_judge.

Verification
REQ-032 Scenario, single hit: play_en=1, note_arrive=0001, then key_pulse=0001 after 3 ticks -> hit_flash=0001 for 1 cycle, score=0001, combo=1.
REQ-033 Scenario, expiry miss: WINDOW_TICKS=16, note_arrive=0100, no key, 16 ticks -> miss_flash=0100 on the 16th tick, combo=0, score unchanged.
REQ-034 Scenario, chord with miss: all 4 lanes armed, keys on 3 lanes, 4th lane expires in the same cycle -> score +3, combo=0.
REQ-035 Scenario, saturation: preload score 9998, 4-lane chord hit -> score=9999; combo at 254 plus 4 hits -> 255.
REQ-036 Scenario, bonus macro: HIT_JUDGE_COMBO_BONUS_EN defined, combo=10, one hit -> score +2; macro undefined -> score +1.
REQ-037 Scenario, edge cases: key_pulse in IDLE -> no change; rst mid-window -> all outputs 0 next cycle, no flash; play_en=0 with 20 ticks -> state held.

Source files
------------

// File: rtl/rg_pkg.sv
// rg_pkg -- shared types and constants for the rhythm-game hit judge.
//   lane_state_e : per-lane FSM state (IDLE, WINDOW)
//   bcd_t        : one BCD score digit
//   NUM_LANES    : number of key lanes (d, f, j, k)
//   SCORE_MAX    : score ceiling (9999, four BCD digits)
//   bcd_add      : adds a small binary value to one BCD digit, returns {carry, digit}
package rg_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } lane_state_e;

  typedef logic [3:0] bcd_t;

  localparam int NUM_LANES = 4;
  localparam int SCORE_MAX = 9999;

  // The addend never exceeds 8, so the raw sum is at most 17 and one
  // decimal correction is always enough.
  function automatic logic [4:0] bcd_add(input bcd_t a, input logic [4:0] b);
    logic [4:0] s;
    s = {1'b0, a} + b;
    if (s > 5'd9) begin
      bcd_add = {1'b1, 4'(s - 5'd10)};
    end else begin
      bcd_add = {1'b0, s[3:0]};
    end
  endfunction

endpackage

// File: rtl/lane_judge.sv
// lane_judge -- one lane's hit-window FSM and tick down-counter.
//   clk, rst         : clock, synchronous active-high reset
//   play_en_i        : when low, state and counter hold and nothing is judged
//   tick_i           : timing strobe that advances the window counter
//   note_i           : note entering the hit zone (opens / reloads the window)
//   key_i            : key press for this lane
//   hit_o / miss_o   : combinational judgement for the current cycle
//   hit_flash_o      : registered one-cycle pulse after a judged hit
//   miss_flash_o     : registered one-cycle pulse after a judged miss
//   state_o          : current FSM state (debug visibility)
module lane_judge
  import rg_pkg::*;
#(
  parameter int unsigned WINDOW_TICKS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        play_en_i,
  input  logic        tick_i,
  input  logic        note_i,
  input  logic        key_i,
  output logic        hit_o,
  output logic        miss_o,
  output logic        hit_flash_o,
  output logic        miss_flash_o,
  output lane_state_e state_o
);

  localparam logic [7:0] WIN_LOAD = 8'(WINDOW_TICKS);

  lane_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        hit_flash_q, miss_flash_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_o   = 1'b0;
    miss_o  = 1'b0;
    if (play_en_i) begin
      unique case (state_q)
        IDLE: begin
          // A key press with no pending note is simply ignored.
          if (note_i) begin
            state_d = WINDOW;
            cnt_d   = WIN_LOAD;
          end
        end
        WINDOW: begin
          if (key_i) begin
            // Key wins over expiry; a simultaneous new note keeps the window open.
            hit_o = 1'b1;
            if (note_i) begin
              cnt_d = WIN_LOAD;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (note_i) begin
            // A new note displaces the unhit pending one.
            miss_o = 1'b1;
            cnt_d  = WIN_LOAD;
          end else if (tick_i) begin
            if (cnt_q == 8'd1) begin
              miss_o  = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hit_flash_q  <= 1'b0;
      miss_flash_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hit_flash_q  <= hit_o;
      miss_flash_q <= miss_o;
    end
  end

  assign hit_flash_o  = hit_flash_q;
  assign miss_flash_o = miss_flash_q;
  assign state_o      = state_q;

endmodule

// File: rtl/hit_judge.sv
// hit_judge -- four-lane rhythm-game judge with BCD score and combo counter.
//   clk, rst             : clock, synchronous active-high reset
//   tick_en              : window timing strobe
//   play_en              : game-running qualifier; low freezes everything
//   note_arrive[3:0]     : per-lane note pulses (k,j,f,d = [3:0])
//   key_pulse[3:0]       : per-lane key pulses
//   score3..score0       : BCD score digits, thousands..units, saturating at 9999
//   combo[7:0]           : consecutive-hit count, saturating at 255
//   hit_flash/miss_flash : per-lane one-cycle judgement pulses
//   lane_state[3:0]      : debug view, bit set while that lane is in WINDOW
// Optional feature: define HIT_JUDGE_COMBO_BONUS_EN to score 2 per hit once the
// pre-update combo is 10 or more.
// Score, combo and flashes all update on the edge after the judging cycle, so
// they become visible together.
module hit_judge
  import rg_pkg::*;
#(
  parameter int unsigned WINDOW_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_en,
  input  logic                 play_en,
  input  logic [NUM_LANES-1:0] note_arrive,
  input  logic [NUM_LANES-1:0] key_pulse,
  output bcd_t                 score3,
  output bcd_t                 score2,
  output bcd_t                 score1,
  output bcd_t                 score0,
  output logic [7:0]           combo,
  output logic [NUM_LANES-1:0] hit_flash,
  output logic [NUM_LANES-1:0] miss_flash,
  output logic [NUM_LANES-1:0] lane_state
);

  logic [NUM_LANES-1:0] hit_j, miss_j;
  lane_state_e          st [NUM_LANES];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_judge #(.WINDOW_TICKS(WINDOW_TICKS)) u_lane (
      .clk          (clk),
      .rst          (rst),
      .play_en_i    (play_en),
      .tick_i       (tick_en),
      .note_i       (note_arrive[g]),
      .key_i        (key_pulse[g]),
      .hit_o        (hit_j[g]),
      .miss_o       (miss_j[g]),
      .hit_flash_o  (hit_flash[g]),
      .miss_flash_o (miss_flash[g]),
      .state_o      (st[g])
    );
    assign lane_state[g] = (st[g] == WINDOW);
  end

  bcd_t       score_q [4];
  bcd_t       score_d [4];
  logic [7:0] combo_q, combo_d;
  logic [2:0] n_hits;
  logic [3:0] pts;
  logic [8:0] combo_sum;
  logic [4:0] add0, add1, add2, add3;

  always_comb begin
    n_hits = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      n_hits = n_hits + 3'(hit_j[i]);
    end
`ifdef HIT_JUDGE_COMBO_BONUS_EN
    // Every hit in the cycle sees the same pre-update combo.
    pts = (combo_q >= 8'd10) ? {n_hits, 1'b0} : {1'b0, n_hits};
`else
    pts = {1'b0, n_hits};
`endif
  end

  // Decimal ripple add; a carry out of the thousands digit means overflow.
  always_comb begin
    add0 = bcd_add(score_q[0], {1'b0, pts});
    add1 = bcd_add(score_q[1], {4'b0, add0[4]});
    add2 = bcd_add(score_q[2], {4'b0, add1[4]});
    add3 = bcd_add(score_q[3], {4'b0, add2[4]});
    if (add3[4]) begin
      for (int i = 0; i < 4; i++) score_d[i] = 4'd9;
    end else begin
      score_d[0] = add0[3:0];
      score_d[1] = add1[3:0];
      score_d[2] = add2[3:0];
      score_d[3] = add3[3:0];
    end
  end

  // Any miss breaks the combo even if other lanes hit in the same cycle.
  always_comb begin
    combo_sum = {1'b0, combo_q} + 9'(n_hits);
    if (|miss_j) begin
      combo_d = '0;
    end else if (combo_sum > 9'd255) begin
      combo_d = 8'hFF;
    end else begin
      combo_d = combo_sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) score_q[i] <= '0;
      combo_q <= '0;
    end else if (play_en) begin
      for (int i = 0; i < 4; i++) score_q[i] <= score_d[i];
      combo_q <= combo_d;
    end
  end

  assign score3 = score_q[3];
  assign score2 = score_q[2];
  assign score1 = score_q[1];
  assign score0 = score_q[0];
  assign combo  = combo_q;

endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge -- self-checking bench for hit_judge (WINDOW_TICKS = 16).
// Each step() drives one cycle of inputs, runs a behavioural lane/score model,
// pushes the expected post-edge outputs to exp_q, then pops and compares them.
module tb_hit_judge;

  localparam int W = 16;

  logic       clk;
  logic       rst;
  logic       tick_en;
  logic       play_en;
  logic [3:0] note_arrive;
  logic [3:0] key_pulse;
  logic [3:0] score3, score2, score1, score0;
  logic [7:0] combo;
  logic [3:0] hit_flash, miss_flash, lane_state;

  hit_judge #(.WINDOW_TICKS(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick_en     (tick_en),
    .play_en     (play_en),
    .note_arrive (note_arrive),
    .key_pulse   (key_pulse),
    .score3      (score3),
    .score2      (score2),
    .score1      (score1),
    .score0      (score0),
    .combo       (combo),
    .hit_flash   (hit_flash),
    .miss_flash  (miss_flash),
    .lane_state  (lane_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [35:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Reference model state
  bit m_win [4];
  int m_cnt [4];
  int m_score;
  int m_combo;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_win[i] = 1'b0;
      m_cnt[i] = 0;
    end
    m_score = 0;
    m_combo = 0;
  endtask

  // Driver: one clock cycle of stimulus plus model update and comparison.
  task automatic step(input logic [3:0] note, input logic [3:0] key,
                      input logic tick, input logic play, input logic r);
    logic [3:0]  h, m, st;
    logic [35:0] e, o;
    int          nh, pts;
    rst = r; play_en = play; tick_en = tick; note_arrive = note; key_pulse = key;
    h = '0; m = '0;
    if (r) begin
      model_clear();
    end else if (play) begin
      for (int i = 0; i < 4; i++) begin
        if (!m_win[i]) begin
          if (note[i]) begin m_win[i] = 1'b1; m_cnt[i] = W; end
        end else if (key[i]) begin
          h[i] = 1'b1;
          if (note[i]) m_cnt[i] = W;
          else begin m_win[i] = 1'b0; m_cnt[i] = 0; end
        end else if (note[i]) begin
          m[i] = 1'b1; m_cnt[i] = W;
        end else if (tick) begin
          if (m_cnt[i] == 1) begin m[i] = 1'b1; m_win[i] = 1'b0; m_cnt[i] = 0; end
          else m_cnt[i] = m_cnt[i] - 1;
        end
      end
      nh  = $countones(h);
      pts = nh;
`ifdef HIT_JUDGE_COMBO_BONUS_EN
      if (m_combo >= 10) pts = 2 * nh;
`endif
      m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
      if (m != 0) m_combo = 0;
      else m_combo = (m_combo + nh > 255) ? 255 : m_combo + nh;
    end
    for (int i = 0; i < 4; i++) st[i] = m_win[i];
    e = {st, h, m, 4'(m_score / 1000), 4'((m_score / 100) % 10),
         4'((m_score / 10) % 10), 4'(m_score % 10), 8'(m_combo)};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {lane_state, hit_flash, miss_flash, score3, score2, score1, score0, combo};
    check_eq("state", 32'(o[35:32]), 32'(e[35:32]));
    check_eq("flash", 32'(o[31:24]), 32'(e[31:24]));
    check_eq("score", 32'(o[23:8]),  32'(e[23:8]));
    check_eq("combo", 32'(o[7:0]),   32'(e[7:0]));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) step(4'h0, 4'h0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic chord(input logic [3:0] lanes);
    step(lanes, 4'h0, 1'b0, 1'b1, 1'b0);
    step(4'h0, lanes, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; tick_en = 1'b0; play_en = 1'b0; note_arrive = '0; key_pulse = '0;
    model_clear();
    @(negedge clk);

    // Reset state
    step(4'h0, 4'h0, 1'b0, 1'b0, 1'b1);
    step(4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_combo", 32'(combo), 32'd0);

    // Single hit on lane 0 after 3 ticks
    step(4'b0001, 4'h0, 1'b0, 1'b1, 1'b0);
    tick(3);
    step(4'h0, 4'b0001, 1'b0, 1'b1, 1'b0);
    check_eq("hit_flash_0001", 32'(hit_flash), 32'h1);
    check_eq("hit_score_1", 32'({score3, score2, score1, score0}), 32'h0001);
    check_eq("hit_combo_1", 32'(combo), 32'd1);
    idle(1);
    check_eq("hit_flash_one_cycle", 32'(hit_flash), 32'h0);

    // Expiry miss on lane 2 after 16 ticks
    step(4'b0100, 4'h0, 1'b0, 1'b1, 1'b0);
    tick(15);
    check_eq("no_miss_before_16", 32'(miss_flash), 32'h0);
    tick(1);
    check_eq("miss_flash_0100", 32'(miss_flash), 32'h4);
    check_eq("miss_combo_0", 32'(combo), 32'd0);
    check_eq("miss_score_held", 32'({score3, score2, score1, score0}), 32'h0001);

    // Chord: keys on 3 lanes while lane 2 expires in the same cycle
    step(4'b1111, 4'h0, 1'b0, 1'b1, 1'b0);
    tick(15);
    step(4'h0, 4'b1011, 1'b1, 1'b1, 1'b0);
    check_eq("chord_score_4", 32'({score3, score2, score1, score0}), 32'h0004);
    check_eq("chord_combo_0", 32'(combo), 32'd0);

    // Key + expiry same cycle is a hit; note + key reloads and stays in window
    step(4'b0001, 4'h0, 1'b0, 1'b1, 1'b0);
    tick(15);
    step(4'h0, 4'b0001, 1'b1, 1'b1, 1'b0);
    step(4'b0010, 4'h0, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 4'b0010, 1'b0, 1'b1, 1'b0);
    step(4'b0010, 4'h0, 1'b0, 1'b1, 1'b0);
    tick(16);

    // Key in IDLE ignored
    step(4'h0, 4'b1111, 1'b0, 1'b1, 1'b0);
    check_eq("idle_key_no_flash", 32'(hit_flash), 32'h0);

    // play_en low for 20 ticks holds everything
    step(4'b1000, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(4'b0101, 4'b1111, 1'b1, 1'b0, 1'b0);
    check_eq("frozen_state", 32'(lane_state), 32'h8);
    step(4'h0, 4'b1000, 1'b0, 1'b1, 1'b0);

    // Reset mid-window: everything clears, no flash
    step(4'b1111, 4'h0, 1'b0, 1'b1, 1'b0);
    tick(5);
    step(4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
    check_eq("rst_mid_flash", 32'({hit_flash, miss_flash}), 32'h0);
    check_eq("rst_mid_state", 32'(lane_state), 32'h0);
    step(4'h0, 4'b1111, 1'b0, 1'b1, 1'b0);

    // Combo to 254, then a 4-lane chord saturates at 255
    for (int i = 0; i < 63; i++) chord(4'b1111);
    chord(4'b0001);
    chord(4'b0010);
    check_eq("combo_254", 32'(combo), 32'd254);
    chord(4'b1111);
    check_eq("combo_sat_255", 32'(combo), 32'd255);

    // Score up to 9998, then a chord saturates at 9999
    while (m_score <= 9998 - 8) chord(4'b1111);
    while (m_score < 9998) chord(4'b0001);
    chord(4'b1111);
    check_eq("score_sat_9999", 32'({score3, score2, score1, score0}), 32'h9999);

    // Randomised traffic, with occasional reset and freeze
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] n, k;
      for (int i = 0; i < 4; i++) begin
        n[i] = ($urandom_range(0, 9) == 0);
        k[i] = ($urandom_range(0, 5) == 0);
      end
      step(n, k, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 299) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
